// File: rtl/iob_ram_sp_be.sv
// -----------------------------------------------------------------------------
// iob_ram_sp_be_ctrl
// Front-end controller for a single-port, byte-enable RAM (iob_ram_sp_be).
// Turns a valid/ready native request into RAM en/we/addr/din strobes and
// returns read data with a one-cycle rvalid pulse.
//
// Optional feature: define IOB_RAM_CTRL_INIT_EN to clear every RAM location
// to INIT_VAL after reset, before the first request is accepted.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   valid, addr, wdata, wstrb  request bus; wstrb == 0 means read
//   ready                      request accepted when valid & ready
//   rdata, rvalid              read result, qualified by the rvalid pulse
//   busy                       high while the init clear runs
//   ram_en, ram_we, ram_addr,  RAM control/data strobes
//   ram_din
//   ram_dout                   RAM read data, valid one cycle after ram_en
// -----------------------------------------------------------------------------
module iob_ram_sp_be_ctrl #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       ADDR_W   = 4,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic                  ready,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rvalid,
   output logic                  busy,
   output logic                  ram_en,
   output logic [DATA_W/8-1:0]   ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_din,
   input  logic [DATA_W-1:0]     ram_dout
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t              state_q;
   logic                ready_q;
   logic                rvalid_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                hs;

   // Accepted request; ready_q is only ever high in RUN
   assign hs = valid & ready_q;

`ifdef IOB_RAM_CTRL_INIT_EN
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;

   // Control FSM with registered ready/busy and the clear address counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= INIT;
               busy_q  <= 1'b1;
            end
            INIT: begin
               cnt_q <= cnt_q + ADDR_W'(1);
               // Last location written this cycle; counter wraps to 0
               if (&cnt_q) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;

   // RAM strobes: clear sequence during INIT, request pass-through otherwise
   always_comb begin
      ram_en   = hs;
      ram_we   = wstrb & {STRB_W{hs}};
      ram_addr = addr;
      ram_din  = wdata;
      if (state_q == INIT) begin
         ram_en   = 1'b1;
         ram_we   = '1;
         ram_addr = cnt_q;
         ram_din  = INIT_VAL;
      end
   end
`else
   logic unused_init_val;

   // Control FSM: IDLE for one cycle after reset, then RUN until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= RUN;
               ready_q <= 1'b1;
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy            = 1'b0;
   assign unused_init_val = ^INIT_VAL;

   // RAM strobes follow the request directly
   always_comb begin
      ram_en   = hs;
      ram_we   = wstrb & {STRB_W{hs}};
      ram_addr = addr;
      ram_din  = wdata;
   end
`endif

   assign ready = ready_q;

   // Read return: pulse one cycle after a read handshake, capture for hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= hs & ~(|wstrb);
         if (rvalid_q) begin
            rdata_q <= ram_dout;
         end
      end
   end

   assign rvalid = rvalid_q;
   // RAM output is live during the pulse; the captured copy holds afterwards
   assign rdata  = rvalid_q ? ram_dout : rdata_q;

endmodule

// File: tb/tb_iob_ram_sp_be_ctrl.sv
module tb_iob_ram_sp_be_ctrl;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned SW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] IV    = 32'hDEADBEEF;
`ifdef IOB_RAM_CTRL_INIT_EN
   localparam bit HAS_INIT = 1'b1;
`else
   localparam bit HAS_INIT = 1'b0;
`endif
   localparam int READY_LAT = HAS_INIT ? DEPTH + 1 : 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wstrb = '0;
   logic          ready, rvalid, busy, ram_en;
   logic [DW-1:0] rdata, ram_din, ram_dout;
   logic [SW-1:0] ram_we;
   logic [AW-1:0] ram_addr;

   int checks = 0;
   int errors = 0;

   iob_ram_sp_be_ctrl #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(IV)) dut (
      .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata),
      .wstrb(wstrb), .ready(ready), .rdata(rdata), .rvalid(rvalid),
      .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port byte-enable RAM with registered read-first output
   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] ram_q;
   always @(posedge clk) begin
      if (ram_en) begin
         ram_q <= ram_mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
   end
   assign ram_dout = ram_q;

   // Reference model: memory image, which words are defined, held read value
   logic [DW-1:0] model [DEPTH];
   bit            known [DEPTH];
   logic [DW-1:0] exp_rd;
   bit            rd_known;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reset, release, then observe ncyc cycles of start-up with valid low
   task automatic startup(input int ncyc);
      valid = 1'b0;
      rst   = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         check("su_ready", ready, (n >= READY_LAT) ? 1 : 0);
         check("su_busy", busy, (HAS_INIT && n >= 1 && n <= DEPTH) ? 1 : 0);
         check("su_rvalid", rvalid, 0);
         if (HAS_INIT && n >= 1 && n <= DEPTH) begin
            check("init_en", ram_en, 1);
            check("init_we", ram_we, 4'hF);
            check("init_addr", ram_addr, n - 1);
            check("init_din", ram_din, IV);
         end else begin
            check("su_en", ram_en, 0);
         end
         @(posedge clk); #1;
      end
      exp_rd   = '0;
      rd_known = 1'b1;
      if (HAS_INIT && ncyc > DEPTH)
         for (int i = 0; i < DEPTH; i++) begin
            model[i] = IV;
            known[i] = 1'b1;
         end
   endtask

   // One RUN-state cycle: drive request, check strobes, advance, check return
   task automatic cyc(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
      bit            is_rd;
      logic [DW-1:0] snap;
      bit            snap_known;
      valid = v; addr = a; wdata = d; wstrb = s;
      #1;
      check("ready", ready, 1);
      check("ram_en", ram_en, v);
      check("ram_we", ram_we, v ? s : 4'h0);
      if (v) begin
         check("ram_addr", ram_addr, a);
         check("ram_din", ram_din, d);
      end
      is_rd      = v && (s == 4'h0);
      snap       = model[a];
      snap_known = known[a];
      if (v && s != 4'h0) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
         known[a] = known[a] || (s == 4'hF);
      end
      @(posedge clk); #1;
      valid = 1'b0;
      check("rvalid", rvalid, is_rd);
      check("busy", busy, 0);
      if (is_rd) begin
         exp_rd   = snap;
         rd_known = snap_known;
      end
      if (rd_known) check("rdata", rdata, exp_rd);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model[i] = '0;
         known[i] = 1'b0;
      end
      exp_rd   = '0;
      rd_known = 1'b1;

      // Reset during the clear, then a full start-up
      startup(8);
      startup(READY_LAT + 4);

      // Back-to-back reads of the whole array
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, AW'(i), $urandom, 4'h0);

      // Full-word writes then readback
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, AW'(i), 32 + i, 4'hF);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, AW'(i), '0, 4'h0);
      check("rd15_final", rdata, 32 + 15);

      // Partial-strobe merge
      cyc(1'b1, 4'd5, 32'h11223344, 4'hF);
      cyc(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
      cyc(1'b1, 4'd5, '0, 4'h0);
      check("merge", rdata, 32'h11BB33DD);

      // Write then read of the same address, and an idle cycle in between
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 4'd3, 32'h5A5A5A5A, 4'hF);
         cyc(1'b1, 4'd3, '0, 4'h0);
         cyc(1'b0, '0, '0, 4'h0);
         check("wr_rd_hold", rdata, 32'h5A5A5A5A);
      end

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         logic [SW-1:0] s;
         s = ($urandom_range(0, 2) == 0) ? 4'h0 : SW'($urandom);
         cyc($urandom_range(0, 3) != 0, AW'($urandom), $urandom, s);
      end

      // Reset with a read in flight drops the pending rvalid
      valid = 1'b1; addr = 4'd2; wstrb = 4'h0;
      #1;
      rst = 1'b1;
      #1;
      check("drop_rvalid", rvalid, 0);
      @(posedge clk); #1;
      check("drop_rvalid2", rvalid, 0);
      check("drop_rdata", rdata, 0);
      valid = 1'b0;
      startup(READY_LAT + 2);
      cyc(1'b1, 4'd5, '0, 4'h0);
      cyc(1'b1, 4'd3, '0, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
